// File: rtl/pulse_mon_pkg.sv
// -----------------------------------------------------------------------------
// pulse_mon_pkg
// Shared definitions for the pulse period monitor:
//   - STATE_W       : width of the monitor state register (2 bits)
//   - state_t       : ST_IDLE / ST_ACQUIRE / ST_LOCKED state encoding
//   - good_cnt_width: width needed to hold the good-period counter 0..LOCK_COUNT-1
// -----------------------------------------------------------------------------
package pulse_mon_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // The good-period counter only ever holds 0..lock_count-1; keep at least one bit.
    function automatic int good_cnt_width(input int lock_count);
        int w;
        if (lock_count > 2) begin
            w = $clog2(lock_count);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage : pulse_mon_pkg

// File: rtl/pulse_edge_detect.sv
// -----------------------------------------------------------------------------
// pulse_edge_detect
// Rising-edge detector for the monitored pulse stream, with an optional
// 2-flop synchroniser in front of it.
//
// Build option: define PULSE_MONITOR_SYNC_EN to insert the synchroniser
// (adds two clocks of latency). Without it, din is assumed synchronous to clk.
//
// Ports:
//   clk      in  1  clock, posedge
//   rst_n    in  1  asynchronous active-low reset
//   din      in  1  raw pulse stream
//   edge_out out 1  high for the single cycle in which the (synchronised)
//                   stream is high and was low on the previous clock
// -----------------------------------------------------------------------------
module pulse_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic edge_out
);

    logic pulse_s;
    logic pulse_d_r;

`ifdef PULSE_MONITOR_SYNC_EN
    logic sync_meta_r;
    logic sync_r;

    // Two-stage synchroniser for an asynchronous pulse source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_r <= 1'b0;
            sync_r      <= 1'b0;
        end else begin
            sync_meta_r <= din;
            sync_r      <= sync_meta_r;
        end
    end

    assign pulse_s = sync_r;
`else
    assign pulse_s = din;
`endif

    // One-clock history of the stream for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_d_r <= 1'b0;
        end else begin
            pulse_d_r <= pulse_s;
        end
    end

    // Left combinational: the monitor registers everything it derives from
    // this, so a register here would only add a clock to every response.
    assign edge_out = pulse_s & ~pulse_d_r;

endmodule : pulse_edge_detect

// File: rtl/pulse_period_monitor.sv
// -----------------------------------------------------------------------------
// pulse_period_monitor
// Measures the number of clocks between rising edges of pulse_in, checks each
// period against EXPECTED_PERIOD +/- TOLERANCE, flags early edges and missing
// (late) edges, and declares lock after LOCK_COUNT consecutive good periods.
//
// Build option: PULSE_MONITOR_SYNC_EN (see pulse_edge_detect) synchronises
// pulse_in before edge detection; measured periods are unaffected.
//
// Parameters:
//   EXPECTED_PERIOD  nominal clocks between rising edges (>= 2)
//   TOLERANCE        allowed +/- deviation in clocks
//   LOCK_COUNT       consecutive good periods needed for lock (>= 1)
//   TIMER_SIZE       MSB index of the interval counter
//
// Ports:
//   clk           in   1             clock, posedge
//   rst_n         in   1             asynchronous active-low reset
//   pulse_in      in   1             monitored pulse stream
//   period_out    out  TIMER_SIZE+1  last measured period
//   period_valid  out  1             strobe: period_out updated
//   locked        out  1             high while in the locked state
//   err_early     out  1             strobe: edge arrived too early
//   err_late      out  1             strobe: no edge within the late limit
// -----------------------------------------------------------------------------
module pulse_period_monitor
    import pulse_mon_pkg::*;
#(
    parameter int EXPECTED_PERIOD = 2,
    parameter int TOLERANCE       = 0,
    parameter int LOCK_COUNT      = 4,
    parameter int TIMER_SIZE      = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pulse_in,
    output logic [TIMER_SIZE:0] period_out,
    output logic                period_valid,
    output logic                locked,
    output logic                err_early,
    output logic                err_late
);

    localparam int CNT_W  = TIMER_SIZE + 1;
    localparam int GOOD_W = good_cnt_width(LOCK_COUNT);

    localparam logic [CNT_W-1:0]  CNT_ZERO    = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]  EARLY_LIMIT = CNT_W'(EXPECTED_PERIOD - TOLERANCE);
    localparam logic [CNT_W-1:0]  LATE_LIMIT  = CNT_W'(EXPECTED_PERIOD + TOLERANCE);
    localparam logic [GOOD_W-1:0] GOOD_ZERO   = GOOD_W'(1'b0);
    localparam logic [GOOD_W-1:0] GOOD_ONE    = GOOD_W'(1'b1);
    localparam logic [GOOD_W-1:0] GOOD_MAX    = GOOD_W'(LOCK_COUNT - 1);

    logic              edge_s;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [GOOD_W-1:0] good_cnt_r;
    logic [GOOD_W-1:0] good_cnt_nxt_s;

    logic [CNT_W-1:0]  period_out_r;
    logic [CNT_W-1:0]  period_nxt_s;
    logic              period_valid_r;
    logic              period_valid_nxt_s;
    logic              locked_r;
    logic              err_early_r;
    logic              err_early_nxt_s;
    logic              err_late_r;
    logic              err_late_nxt_s;

    pulse_edge_detect u_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (pulse_in),
        .edge_out (edge_s)
    );

    // Next-state, counter and strobe decode.
    always_comb begin
        state_nxt_s        = state_r;
        cnt_nxt_s          = cnt_r;
        good_cnt_nxt_s     = good_cnt_r;
        period_nxt_s       = period_out_r;
        period_valid_nxt_s = 1'b0;
        err_early_nxt_s    = 1'b0;
        err_late_nxt_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                good_cnt_nxt_s = GOOD_ZERO;
                if (edge_s) begin
                    // First edge only opens a period; nothing to measure yet.
                    state_nxt_s = ST_ACQUIRE;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end

            ST_ACQUIRE, ST_LOCKED: begin
                if (edge_s) begin
                    // An edge on the late-limit cycle still counts as good:
                    // the edge test takes priority over the timeout test.
                    period_nxt_s       = cnt_r;
                    period_valid_nxt_s = 1'b1;
                    cnt_nxt_s          = CNT_ONE;
                    if (cnt_r < EARLY_LIMIT) begin
                        err_early_nxt_s = 1'b1;
                        good_cnt_nxt_s  = GOOD_ZERO;
                        state_nxt_s     = ST_ACQUIRE;
                    end else if ((state_r == ST_ACQUIRE) && (good_cnt_r == GOOD_MAX)) begin
                        state_nxt_s = ST_LOCKED;
                    end else if (good_cnt_r < GOOD_MAX) begin
                        good_cnt_nxt_s = good_cnt_r + GOOD_ONE;
                    end else begin
                        good_cnt_nxt_s = good_cnt_r;
                    end
                end else if (cnt_r >= LATE_LIMIT) begin
                    // Missing edge: drop back so a late edge is never measured.
                    err_late_nxt_s = 1'b1;
                    state_nxt_s    = ST_IDLE;
                    cnt_nxt_s      = CNT_ZERO;
                    good_cnt_nxt_s = GOOD_ZERO;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end

            default: begin
                state_nxt_s    = ST_IDLE;
                cnt_nxt_s      = CNT_ZERO;
                good_cnt_nxt_s = GOOD_ZERO;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            cnt_r          <= CNT_ZERO;
            good_cnt_r     <= GOOD_ZERO;
            period_out_r   <= CNT_ZERO;
            period_valid_r <= 1'b0;
            locked_r       <= 1'b0;
            err_early_r    <= 1'b0;
            err_late_r     <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            cnt_r          <= cnt_nxt_s;
            good_cnt_r     <= good_cnt_nxt_s;
            period_out_r   <= period_nxt_s;
            period_valid_r <= period_valid_nxt_s;
            locked_r       <= (state_nxt_s == ST_LOCKED);
            err_early_r    <= err_early_nxt_s;
            err_late_r     <= err_late_nxt_s;
        end
    end

    assign period_out   = period_out_r;
    assign period_valid = period_valid_r;
    assign locked       = locked_r;
    assign err_early    = err_early_r;
    assign err_late     = err_late_r;

endmodule : pulse_period_monitor

// File: tb/tb_pulse_period_monitor.sv
// -----------------------------------------------------------------------------
// tb_pulse_period_monitor
// Directed bench for pulse_period_monitor with EXPECTED_PERIOD=5, TOLERANCE=1,
// LOCK_COUNT=3. A table of edge gaps with hand-computed responses covers
// acquisition, lock, early edges, relock and the 4/6 boundaries; hand-written
// sequences cover timeout, a level held high and asynchronous reset.
// When PULSE_MONITOR_SYNC_EN is defined all responses are expected 2 clocks later.
// -----------------------------------------------------------------------------
module tb_pulse_period_monitor;

    localparam int EP  = 5;
    localparam int TOL = 1;
    localparam int LC  = 3;
    localparam int TS  = 15;
`ifdef PULSE_MONITOR_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pulse_in;
    logic [TS:0]   period_out;
    logic          period_valid;
    logic          locked;
    logic          err_early;
    logic          err_late;

    int checks   = 0;
    int failures = 0;
    int consumed = 0;

    typedef struct {
        int   gap;
        logic exp_valid;
        int   exp_period;
        logic exp_early;
        logic exp_lock;
    } vec_t;

    vec_t vecs[11];

    pulse_period_monitor #(
        .EXPECTED_PERIOD (EP),
        .TOLERANCE       (TOL),
        .LOCK_COUNT      (LC),
        .TIMER_SIZE      (TS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pulse_in     (pulse_in),
        .period_out   (period_out),
        .period_valid (period_valid),
        .locked       (locked),
        .err_early    (err_early),
        .err_late     (err_late)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Drive one clock of input, then sample just after the edge.
    task automatic tick(input logic p);
        pulse_in = p;
        @(posedge clk);
        #1;
    endtask

    // Rising edge 'gap' clocks after the previous one; return once its response is visible.
    task automatic edge_after(input int gap);
        for (int i = consumed; i < gap - 1; i++) tick(1'b0);
        tick(1'b1);
        for (int i = 0; i < LAT; i++) tick(1'b0);
        consumed = LAT;
    endtask

    // Compare all outputs; exp_period < 0 skips the period_out comparison.
    task automatic check_outs(input string tag, input logic v, input int p,
                              input logic ee, input logic el, input logic lk);
        check({tag, "_valid"}, {31'd0, period_valid}, {31'd0, v});
        if (p >= 0) check({tag, "_period"}, {16'd0, period_out}, p);
        check({tag, "_early"}, {31'd0, err_early}, {31'd0, ee});
        check({tag, "_late"}, {31'd0, err_late}, {31'd0, el});
        check({tag, "_locked"}, {31'd0, locked}, {31'd0, lk});
    endtask

    // Let the counter run out after the last edge: err_late 7 clocks after it.
    task automatic expect_timeout(input string tag, input logic lock_before);
        for (int i = consumed; i < (EP + TOL - 1) + LAT; i++) tick(1'b0);
        check_outs({tag, "_pre"}, 1'b0, -1, 1'b0, 1'b0, lock_before);
        tick(1'b0);
        check_outs({tag, "_hit"}, 1'b0, -1, 1'b0, 1'b1, 1'b0);
        tick(1'b0);
        check({tag, "_late_clear"}, {31'd0, err_late}, 32'd0);
        consumed = 0;
    endtask

    initial begin
        vecs[0]  = '{gap: 1, exp_valid: 1'b0, exp_period: 0, exp_early: 1'b0, exp_lock: 1'b0};
        vecs[1]  = '{gap: 5, exp_valid: 1'b1, exp_period: 5, exp_early: 1'b0, exp_lock: 1'b0};
        vecs[2]  = '{gap: 5, exp_valid: 1'b1, exp_period: 5, exp_early: 1'b0, exp_lock: 1'b0};
        vecs[3]  = '{gap: 5, exp_valid: 1'b1, exp_period: 5, exp_early: 1'b0, exp_lock: 1'b1};
        vecs[4]  = '{gap: 5, exp_valid: 1'b1, exp_period: 5, exp_early: 1'b0, exp_lock: 1'b1};
        vecs[5]  = '{gap: 3, exp_valid: 1'b1, exp_period: 3, exp_early: 1'b1, exp_lock: 1'b0};
        vecs[6]  = '{gap: 5, exp_valid: 1'b1, exp_period: 5, exp_early: 1'b0, exp_lock: 1'b0};
        vecs[7]  = '{gap: 5, exp_valid: 1'b1, exp_period: 5, exp_early: 1'b0, exp_lock: 1'b0};
        vecs[8]  = '{gap: 5, exp_valid: 1'b1, exp_period: 5, exp_early: 1'b0, exp_lock: 1'b1};
        vecs[9]  = '{gap: 4, exp_valid: 1'b1, exp_period: 4, exp_early: 1'b0, exp_lock: 1'b1};
        vecs[10] = '{gap: 6, exp_valid: 1'b1, exp_period: 6, exp_early: 1'b0, exp_lock: 1'b1};

        rst_n    = 1'b0;
        pulse_in = 1'b0;
        @(posedge clk);
        #1;
        tick(1'b1);
        check_outs("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        pulse_in = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0);
        check_outs("idle", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        consumed = 0;

        // Table: acquisition, lock, early edge, relock, 4/6 boundaries.
        for (int i = 0; i < 11; i++) begin
            edge_after(vecs[i].gap);
            check_outs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_period,
                       vecs[i].exp_early, 1'b0, vecs[i].exp_lock);
        end

        // Missing edge while locked, then the next edge restarts acquisition.
        expect_timeout("late1", 1'b1);
        edge_after(1);
        check_outs("restart_edge", 1'b0, -1, 1'b0, 1'b0, 1'b0);
        edge_after(5);
        check_outs("restart_period", 1'b1, 5, 1'b0, 1'b0, 1'b0);
        expect_timeout("late2", 1'b0);

        // Level held high: one edge only, then a timeout 7 clocks after it.
        for (int i = 0; i < 20; i++) begin
            tick(1'b1);
            check($sformatf("high%0d_late", i), {31'd0, err_late}, {31'd0, (i == EP + TOL + LAT)});
            check($sformatf("high%0d_valid", i), {31'd0, period_valid}, 32'd0);
            check($sformatf("high%0d_early", i), {31'd0, err_early}, 32'd0);
        end
        for (int i = 0; i < 3; i++) tick(1'b0);
        consumed = 0;
        edge_after(1);
        check_outs("after_high_edge", 1'b0, -1, 1'b0, 1'b0, 1'b0);

        // Relock from IDLE, then asynchronous reset while locked.
        edge_after(5);
        check_outs("relock1", 1'b1, 5, 1'b0, 1'b0, 1'b0);
        edge_after(5);
        check_outs("relock2", 1'b1, 5, 1'b0, 1'b0, 1'b0);
        edge_after(5);
        check_outs("relock3", 1'b1, 5, 1'b0, 1'b0, 1'b1);
        #2;
        pulse_in = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        consumed = 0;
        edge_after(1);
        check_outs("post_rst_edge", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        edge_after(5);
        check_outs("post_rst_period", 1'b1, 5, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pulse_period_monitor

// File: doc/pulse_period_monitor.md
Name: pulse_period_monitor

Overview:
- Receive-side counterpart of the periodic pulse generator: watches a single-bit pulse stream and measures the clock count between rising edges.
- Checks each period against an expected value with tolerance, flags early and late (missing) pulses, and declares lock after N consecutive good periods.
- Sits downstream of any pulse source as a health and timing check.

Parameters:
- EXPECTED_PERIOD, 2, nominal clocks between consecutive pulse rising edges; must be >= 2.
- TOLERANCE, 0, allowed ± deviation in clocks; EXPECTED_PERIOD - TOLERANCE must be >= 1.
- LOCK_COUNT, 4, consecutive in-tolerance periods required to assert locked; must be >= 1.
- TIMER_SIZE, 15, MSB index of the interval counter (width TIMER_SIZE+1); EXPECTED_PERIOD + TOLERANCE must be < 2^(TIMER_SIZE+1).

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- pulse_in  input  1  monitored pulse stream; only rising edges count.
- period_out  output  TIMER_SIZE+1  last measured period in clocks.
- period_valid  output  1  one-cycle strobe; period_out was updated.
- locked  output  1  high while in LOCKED state.
- err_early  output  1  one-cycle strobe; an edge arrived with period < EXPECTED_PERIOD - TOLERANCE.
- err_late  output  1  one-cycle strobe; no edge arrived by EXPECTED_PERIOD + TOLERANCE clocks.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, cnt=0, good_cnt=0, edge-detect history=0.
- Edge: e = p & ~p_d, where p is pulse_in (or its synchronised copy) and p_d is p delayed one clock. A level held high yields one edge.
- States (2-bit): IDLE=0, ACQUIRE=1, LOCKED=2.
- IDLE: cnt held at 0. On e: go to ACQUIRE, cnt<=1. No period is measured on the first edge.
- ACQUIRE/LOCKED, no e: cnt<=cnt+1.
- Timeout: if cnt == EXPECTED_PERIOD + TOLERANCE and no e in that cycle:
  - err_late=1 next cycle, state<=IDLE, cnt<=0, good_cnt<=0, locked<=0.
  - Late edges are therefore never measured; the next edge restarts acquisition from IDLE.
- ACQUIRE/LOCKED with e:
  - period_out<=cnt, period_valid=1 next cycle, cnt<=1 (this edge starts the next period).
  - If cnt < EXPECTED_PERIOD - TOLERANCE (early): err_early=1, good_cnt<=0, state<=ACQUIRE, locked<=0.
  - Otherwise (good): if state is ACQUIRE and good_cnt == LOCK_COUNT-1, state<=LOCKED and locked<=1; else good_cnt<=good_cnt+1, saturating at LOCK_COUNT-1.
- Latency: all outputs are registered one clock after the edge or timeout cycle.
- Strobes are mutually exclusive in a cycle, except that period_valid accompanies err_early.
- Simultaneous e and cnt == EXPECTED_PERIOD + TOLERANCE: the edge wins (good period, no err_late).
- Reset mid-operation: immediate return to reset values; any in-flight period is discarded.

Optional Feature:
- PULSE_MONITOR_SYNC_EN defined: pulse_in passes through a 2-flop synchroniser before edge detection. This adds 2 clocks of latency to all responses; measured periods are unchanged. Synchroniser flops reset to 0.
- Undefined: pulse_in is treated as synchronous to clk and feeds the edge detector directly.

Decomposition:
- Package pulse_mon_pkg: state typedef/localparams (ST_IDLE, ST_ACQUIRE, ST_LOCKED) and the 2-bit state width constant.
- Sub-module pulse_edge_detect (clk, rst_n, din, edge_out): contains the optional synchroniser and the rising-edge detector.
- Top module holds the counter, FSM and checks.

Test Plan:
- EXPECTED_PERIOD=5, TOLERANCE=1, LOCK_COUNT=3; rising edges every 5 clocks ×5 -> period_valid with period_out=5 after edges 2–5; locked=1 one clock after edge 4; no errors.
- Locked, then next edge 3 clocks later -> err_early=1, period_valid=1, period_out=3, locked=0; three further 5-clock periods -> relock.
- Periods of 4 and 6 -> both accepted (boundary); a 7-clock gap -> err_late one clock after cnt reaches 6, locked=0, state IDLE; the next edge produces no period_valid.
- pulse_in held high for 20 clocks -> exactly one edge; err_late fires 7 clocks after that edge (counter reaches 6, output registered one clock later).
- rst_n pulsed low asynchronously while locked -> all outputs 0 immediately; the first edge after release gives no period_valid.
- With PULSE_MONITOR_SYNC_EN: repeat scenario 1 -> identical period_out values, all strobes delayed by 2 clocks.
